traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Request arbiter and phase sequencer for the intersection light controller.
- Captures the five traffic/pedestrian sensor requests and holds each as sticky pending.
- Shares the single light-phase executor among them by round-robin, enforcing a minimum main-street green between bursts.
- Issues one phase command at a time (id plus duration in seconds) over a valid/ready handshake, then waits for the executor's done pulse.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (50 MHz board clock)
MAIN_MIN, 6, minimum main-green seconds before any request is served; also the MAIN_GO duration
GO_SEC, 6, duration for CROSS_GO, WALK_MAIN, WALK_CROSS phases
ARROW_SEC, 4, duration for MAIN_ARROW and CROSS_ARROW phases
MAX_BURST, 3, maximum requests served back-to-back before returning to MAIN_GO (1..7)

Ports:
clk  input  1  board clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
sensors  input  5  raw requests: [0] left main, [1] left cross, [2] cross traffic, [3] walk main, [4] walk cross
phase_valid  output  1  phase command valid
phase_id  output  3  0 MAIN_GO, 1 MAIN_ARROW, 2 CROSS_ARROW, 3 CROSS_GO, 4 WALK_MAIN, 5 WALK_CROSS
phase_dur  output  4  phase duration in seconds
phase_ready  input  1  executor accepts command
phase_done  input  1  one-cycle pulse: executor finished current phase
pending  output  5  sticky request flags
busy  output  1  high whenever the FSM is not in S_MAIN

Behaviour:
- Reset (async, rst_n=0):
  - phase_valid=0, phase_id=0, phase_dur=0, pending=0, busy=1.
  - Round-robin pointer rr=0, burst count=0, tick divider=0, sec_cnt=0, sync flops=0, state=S_ISSUE_MAIN.
- Reset mid-operation discards any in-flight command; the first command after release is always MAIN_GO.
- Input capture:
  - Two-flop synchronizer per sensor bit, then a rising-edge detect.
  - An edge on bit i sets pending[i].
  - pending[i] clears in the cycle a command for requester i transfers (valid&&ready).
  - If the edge and the clear hit the same bit in the same cycle, the bit stays set.
  - A held-high sensor does not re-request.
- Tick: the divider counts 0..TICK_DIV-1 and wraps; tick is a 1-cycle pulse at TICK_DIV-1. It is free-running and never reset by the FSM.
- Requester i maps to phase_id i+1.
- Durations: MAIN_GO=MAIN_MIN, ids 1-2 = ARROW_SEC, ids 3-5 = GO_SEC; each truncated to 4 bits.
- Handshake:
  - phase_valid, phase_id and phase_dur are registered and held stable while valid&&!ready.
  - Transfer occurs on a cycle with valid&&ready; phase_valid drops the next cycle.
  - Zero-latency accept is legal.
- FSM:
  - S_ISSUE_MAIN: valid=1, id=0, dur=MAIN_MIN. On transfer: sec_cnt=0, burst=0, go to S_MAIN.
  - S_MAIN: busy=0. sec_cnt increments on tick and saturates at 15. When sec_cnt>=MAIN_MIN and pending!=0, go to S_ARB. With no requests, remain in S_MAIN indefinitely.
  - S_ARB (1 cycle): pick the first set pending bit searching rr, rr+1, ... mod 5. Latch grant g, load id and dur, go to S_ISSUE.
  - S_ISSUE: valid=1. On transfer: clear pending[g], set rr=(g+1) mod 5 (4 wraps to 0), increment burst, go to S_RUN.
  - S_RUN: wait for phase_done.
    - If pending!=0 and burst<MAX_BURST, go to S_ARB.
    - Otherwise go to S_ISSUE_MAIN.
- Priority is purely round-robin; no sensor has fixed priority.
- A request arriving during S_RUN is eligible at the next S_ARB.
- phase_done outside S_RUN is ignored.
- phase_done coincident with a new sensor edge: the new pending bit counts in that cycle's decision.
- If pending becomes 0 in S_ARB (not possible after a qualified entry), return to S_ISSUE_MAIN.

Test Plan:
All scenarios use TICK_DIV=10, MAIN_MIN=6, GO_SEC=6, ARROW_SEC=4, MAX_BURST=3, with phase_ready tied 1 unless stated.
1. Reset release with no sensors -> single MAIN_GO transfer (id 0, dur 6), then busy=0 and no further phase_valid for 500 cycles; rst_n pulsed low mid-run -> all outputs return to their reset values immediately.
2. Pulse sensors[2] 1 tick after MAIN_GO accept -> pending=00100; no grant until sec_cnt reaches 6 (~60 cycles); then id 3, dur 6, and pending clears on transfer; done pulse -> MAIN_GO reissued.
3. Raise sensors[1], [2] and [4] together during S_MAIN -> grants in order id 2, 3, 5, then MAIN_GO after the third done (burst limit 3); rr ends at 0.
4. Hold sensors[0] high across its grant -> exactly one MAIN_ARROW (id 1, dur 4); a second rising edge after release -> second grant in the next cycle.
5. phase_ready held 0 for 20 cycles in S_ISSUE -> phase_valid, phase_id and phase_dur stable; pending bit stays set until the ready cycle.
6. Sensor[3] edge in the same cycle pending[3] is cleared by transfer -> pending[3] remains 1; WALK_MAIN (id 4) is granted again on the next arbitration.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Round-robin arbiter and phase sequencer for the intersection light executor.
// Sensor requests are synchronised, edge-detected and held pending until their phase command transfers.
module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 50000000,
  parameter int MAIN_MIN  = 6,
  parameter int GO_SEC    = 6,
  parameter int ARROW_SEC = 4,
  parameter int MAX_BURST = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sensors,
  output logic       phase_valid,
  output logic [2:0] phase_id,
  output logic [3:0] phase_dur,
  input  logic       phase_ready,
  input  logic       phase_done,
  output logic [4:0] pending,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0] MAIN_DUR  = 4'(MAIN_MIN);
  localparam logic [3:0] ARROW_DUR = 4'(ARROW_SEC);
  localparam logic [3:0] GO_DUR    = 4'(GO_SEC);

  typedef enum logic [2:0] {
    S_ISSUE_MAIN = 3'd0,
    S_MAIN       = 3'd1,
    S_ARB        = 3'd2,
    S_ISSUE      = 3'd3,
    S_RUN        = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [4:0]       pending_q, pending_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       sec_q, sec_d;
  logic [2:0]       rr_q, rr_d, grant_q, grant_d, burst_q, burst_d;
  logic             valid_q, valid_d;
  logic [2:0]       id_q, id_d;
  logic [3:0]       dur_q, dur_d;

  logic [4:0] rise, pend_now, clr;
  logic       tick, xfer, arb_found;
  logic [2:0] arb_g, cand;
  logic [3:0] cand_sum;

  function automatic logic [3:0] dur_of(input logic [2:0] id);
    if (id == 3'd0) return MAIN_DUR;
    if (id <= 3'd2) return ARROW_DUR;
    return GO_DUR;
  endfunction

  always_comb begin
    rise     = sync2_q & ~prev_q;
    pend_now = pending_q | rise;
    tick     = (div_q == DIV_LAST);
    xfer     = valid_q & phase_ready;

    // Round-robin search starting at rr; a same-cycle edge is already eligible.
    arb_found = 1'b0;
    arb_g     = 3'd0;
    cand_sum  = 4'd0;
    cand      = 3'd0;
    for (int k = 0; k < 5; k++) begin
      cand_sum = {1'b0, rr_q} + 4'(k);
      if (cand_sum >= 4'd5) cand_sum = cand_sum - 4'd5;
      cand = cand_sum[2:0];
      if (!arb_found && pend_now[cand]) begin
        arb_found = 1'b1;
        arb_g     = cand;
      end
    end

    state_d = state_q;
    sync1_d = sensors;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    sec_d   = sec_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    burst_d = burst_q;
    valid_d = valid_q;
    id_d    = id_q;
    dur_d   = dur_q;
    clr     = 5'd0;

    case (state_q)
      S_ISSUE_MAIN: begin
        if (xfer) begin
          valid_d = 1'b0;
          sec_d   = 4'd0;
          burst_d = 3'd0;
          state_d = S_MAIN;
        end else begin
          valid_d = 1'b1;
          id_d    = 3'd0;
          dur_d   = dur_of(3'd0);
        end
      end
      S_MAIN: begin
        if (tick && sec_q != 4'hF) sec_d = sec_q + 4'd1;
        if (int'(sec_q) >= MAIN_MIN && pend_now != 5'd0) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          grant_d = arb_g;
          id_d    = arb_g + 3'd1;
          dur_d   = dur_of(arb_g + 3'd1);
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_ISSUE_MAIN;
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          valid_d      = 1'b0;
          clr[grant_q] = 1'b1;
          rr_d         = (grant_q == 3'd4) ? 3'd0 : grant_q + 3'd1;
          burst_d      = burst_q + 3'd1;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (phase_done) begin
          if (pend_now != 5'd0 && int'(burst_q) < MAX_BURST) state_d = S_ARB;
          else state_d = S_ISSUE_MAIN;
        end
      end
      default: state_d = S_ISSUE_MAIN;
    endcase

    // A new edge on the bit being cleared wins, so the request is not lost.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ISSUE_MAIN;
      sync1_q   <= 5'd0;
      sync2_q   <= 5'd0;
      prev_q    <= 5'd0;
      pending_q <= 5'd0;
      div_q     <= '0;
      sec_q     <= 4'd0;
      rr_q      <= 3'd0;
      grant_q   <= 3'd0;
      burst_q   <= 3'd0;
      valid_q   <= 1'b0;
      id_q      <= 3'd0;
      dur_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      div_q     <= div_d;
      sec_q     <= sec_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      burst_q   <= burst_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      dur_q     <= dur_d;
    end
  end

  assign phase_valid = valid_q;
  assign phase_id    = id_q;
  assign phase_dur   = dur_q;
  assign pending     = pending_q;
  assign busy        = (state_q != S_MAIN);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of requests, round-robin grants and command timing.
module tb_traffic_phase_scheduler;
  localparam int TICK_DIV  = 10;
  localparam int MAIN_MIN  = 6;
  localparam int GO_SEC    = 6;
  localparam int ARROW_SEC = 4;
  localparam int MAX_BURST = 3;
  localparam int DWELL_LO  = (MAIN_MIN - 1) * TICK_DIV + 2;
  localparam int DWELL_HI  = MAIN_MIN * TICK_DIV + 3;
  localparam int W_CMD = 0, W_MAIN = 1, W_DONE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sensors = 5'd0;
  logic       phase_ready = 1'b1;
  logic       phase_done = 1'b0;
  logic       phase_valid;
  logic [2:0] phase_id;
  logic [3:0] phase_dur;
  logic [4:0] pending;
  logic       busy;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [4:0] pm, h1, h2, h3, rise_m, clr_m, nxt_m;
  int         mode, m0, due, rr_m, burst_m, since_main, stall_cnt, g_m, exp_id, exp_dur;
  logic       exp_main;
  logic [2:0] xfer_id_q[$];
  logic [3:0] xfer_dur_q[$];
  logic [2:0] exp_q[$];

  traffic_phase_scheduler #(
    .TICK_DIV(TICK_DIV), .MAIN_MIN(MAIN_MIN), .GO_SEC(GO_SEC),
    .ARROW_SEC(ARROW_SEC), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensors(sensors),
    .phase_valid(phase_valid), .phase_id(phase_id), .phase_dur(phase_dur),
    .phase_ready(phase_ready), .phase_done(phase_done),
    .pending(pending), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [4:0] p, input int start);
    for (int k = 0; k < 5; k++) begin
      if (p[(start + k) % 5]) return (start + k) % 5;
    end
    return -1;
  endfunction

  // Compare process: inputs change just after posedge, so everything is stable here.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", phase_valid, 0);
      check("rst_id", phase_id, 0);
      check("rst_dur", phase_dur, 0);
      check("rst_pending", pending, 0);
      check("rst_busy", busy, 1);
      pm = 5'd0; h1 = 5'd0; h2 = 5'd0; h3 = 5'd0;
      mode = W_CMD; due = 2; exp_main = 1'b1; exp_id = 0; exp_dur = MAIN_MIN;
      rr_m = 0; burst_m = 0; since_main = 0; stall_cnt = 0; g_m = 0;
    end else begin
      rise_m = h2 & ~h3;
      clr_m  = 5'd0;
      m0     = mode;
      check("pending", pending, pm);

      if (m0 == W_DONE) begin
        check("run_valid", phase_valid, 0);
        check("run_busy", busy, 1);
        if (phase_done) begin
          nxt_m    = pm | rise_m;
          exp_main = !(nxt_m != 5'd0 && burst_m < MAX_BURST);
          mode     = W_CMD;
          due      = 2;
        end
      end

      if (m0 == W_MAIN) begin
        if (phase_valid) begin
          check("main_dwell", since_main >= DWELL_LO, 1);
          exp_main = 1'b0;
          mode     = W_CMD;
          due      = 0;
          g_m      = rr_pick(pm, rr_m);
          check("grant_nonempty", g_m >= 0, 1);
          exp_id   = g_m + 1;
          exp_dur  = (g_m < 2) ? ARROW_SEC : GO_SEC;
        end else begin
          if (pm == 5'd0) check("main_busy", busy, 0);
          if (pm != 5'd0 && since_main >= DWELL_HI) begin
            stall_cnt++;
            check("grant_late", stall_cnt <= 2, 1);
          end
        end
      end

      if (m0 == W_CMD || (m0 == W_MAIN && mode == W_CMD)) begin
        check("cmd_busy", busy, 1);
        if (due > 0) begin
          due--;
          if (due > 0) begin
            check("valid_early", phase_valid, 0);
          end else begin
            check("valid_due", phase_valid, 1);
            if (exp_main) begin
              exp_id = 0; exp_dur = MAIN_MIN;
            end else begin
              g_m = rr_pick(pm, rr_m);
              check("grant_nonempty", g_m >= 0, 1);
              exp_id  = g_m + 1;
              exp_dur = (g_m < 2) ? ARROW_SEC : GO_SEC;
            end
          end
        end else begin
          check("valid_hold", phase_valid, 1);
        end
        if (phase_valid) begin
          check("cmd_id", phase_id, exp_id);
          check("cmd_dur", phase_dur, exp_dur);
          if (phase_ready) begin
            xfer_id_q.push_back(phase_id);
            xfer_dur_q.push_back(phase_dur);
            if (exp_main) begin
              burst_m = 0; mode = W_MAIN; since_main = 0; stall_cnt = 0;
            end else begin
              clr_m[g_m] = 1'b1;
              rr_m = (g_m + 1) % 5;
              burst_m++;
              mode = W_DONE;
            end
          end
        end
      end

      pm = (pm & ~clr_m) | rise_m;
      h3 = h2; h2 = h1; h1 = sensors;
      if (since_main < 1000000) since_main++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    xfer_id_q.delete();
    xfer_dur_q.delete();
  endtask

  task automatic pulse_done();
    phase_done = 1'b1;
    step(1);
    phase_done = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int k = 0;
    while (xfer_id_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(name, xfer_id_q.size() >= n, 1);
  endtask

  task automatic check_log(input string name, input int base);
    int i = base;
    while (exp_q.size() > 0) begin
      if (i < xfer_id_q.size()) check(name, xfer_id_q[i], exp_q[0]);
      else check(name, 32'hFFFF_FFFF, exp_q[0]);
      void'(exp_q.pop_front());
      i++;
    end
  endtask

  initial begin
    // 1: idle after reset, then asynchronous reset mid-run
    step(1);
    reset_dut();
    step(510);
    check("t1_count", xfer_id_q.size(), 1);
    if (xfer_id_q.size() >= 1) begin
      check("t1_id", xfer_id_q[0], 0);
      check("t1_dur", xfer_dur_q[0], 6);
    end
    check("t1_idle_busy", busy, 0);
    rst_n = 1'b0;
    #1;
    check("t1_async_valid", phase_valid, 0);
    check("t1_async_dur", phase_dur, 0);
    check("t1_async_busy", busy, 1);
    check("t1_async_pending", pending, 0);
    step(2);
    rst_n = 1'b1;
    xfer_id_q.delete();
    xfer_dur_q.delete();

    // 2: single cross-traffic request waits out main green
    wait_xfers(1, 20, "t2_main");
    step(10);
    sensors = 5'b00100;
    step(2);
    sensors = 5'b00000;
    step(4);
    check("t2_pending", pending, 5'b00100);
    wait_xfers(2, 100, "t2_grant");
    if (xfer_id_q.size() >= 2) begin
      check("t2_id", xfer_id_q[1], 3);
      check("t2_dur", xfer_dur_q[1], 6);
    end
    check("t2_clear", pending, 0);
    step(3);
    pulse_done();
    wait_xfers(3, 10, "t2_remain");
    exp_q.push_back(3'd0);
    check_log("t2_main_again", 2);

    // 3: three simultaneous requests served round-robin, then main green
    reset_dut();
    wait_xfers(1, 20, "t3_main");
    step(5);
    sensors = 5'b10110;
    step(2);
    sensors = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      wait_xfers(i + 2, 120, "t3_grant");
      step(3);
      pulse_done();
    end
    wait_xfers(5, 10, "t3_main_again");
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    exp_q.push_back(3'd5); exp_q.push_back(3'd0);
    check_log("t3_seq", 0);

    // 4: rr back at 0 (left-main wins over walk-cross); held sensor does not re-request
    step(5);
    sensors = 5'b10001;
    step(2);
    sensors = 5'b00001;
    wait_xfers(6, 120, "t4_grant");
    if (xfer_dur_q.size() >= 6) check("t4_dur", xfer_dur_q[5], 4);
    step(3);
    pulse_done();
    wait_xfers(7, 10, "t4_grant2");
    step(3);
    pulse_done();
    wait_xfers(8, 10, "t4_main");
    step(100);
    check("t4_no_rerequest", xfer_id_q.size(), 8);
    sensors = 5'b00000;
    step(5);
    sensors = 5'b00001;
    step(2);
    sensors = 5'b00000;
    wait_xfers(9, 10, "t4_second_edge");
    step(3);
    pulse_done();
    wait_xfers(10, 10, "t4_main2");
    exp_q.push_back(3'd1); exp_q.push_back(3'd5); exp_q.push_back(3'd0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    check_log("t4_seq", 5);

    // 5: executor stalls; command held stable, request stays pending
    phase_ready = 1'b0;
    step(10);
    sensors = 5'b01000;
    step(2);
    sensors = 5'b00000;
    begin
      int k = 0;
      while (!phase_valid && k < 100) begin
        step(1);
        k++;
      end
    end
    check("t5_valid", phase_valid, 1);
    step(20);
    check("t5_hold_valid", phase_valid, 1);
    check("t5_hold_id", phase_id, 4);
    check("t5_hold_dur", phase_dur, 6);
    check("t5_pending", pending, 5'b01000);

    // 6: new edge on the same bit in the transfer cycle keeps it pending
    sensors = 5'b01000;
    step(2);
    phase_ready = 1'b1;
    step(1);
    check("t6_pending_kept", pending, 5'b01000);
    sensors = 5'b00000;
    step(3);
    pulse_done();
    wait_xfers(12, 10, "t6_regrant");
    check("t6_cleared", pending, 0);
    step(3);
    pulse_done();
    wait_xfers(13, 10, "t6_main");
    exp_q.push_back(3'd4); exp_q.push_back(3'd4); exp_q.push_back(3'd0);
    check_log("t6_seq", 10);

    // Random traffic, stalls, spurious done pulses and occasional resets
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) sensors = sensors ^ 5'($urandom_range(1, 31));
      phase_ready = ($urandom_range(0, 3) != 0);
      phase_done  = !phase_done && ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end else begin
        step(1);
      end
    end
    sensors = 5'd0;
    phase_done = 1'b0;
    phase_ready = 1'b1;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
